// File: rtl/hamming_serial_rx.sv
// UART-style receiver for 7-bit Hamming codewords: start, 7 data LSB-first, optional even parity, stop.
// Build with RX_PARITY_EN defined to expect the even-parity bit between the last data bit and stop.
//
// state  | meaning
// IDLE   | line idle, waiting for a synchronised 1->0 edge
// START  | timing to the middle of the start bit to reject glitches
// DATA   | sampling data bits 0..6 at bit centres
// PARITY | sampling the even-parity bit (RX_PARITY_EN builds only)
// STOP   | sampling the stop bit, publishing the word or flagging an error
// BREAK  | line held low after a bad stop bit, waiting for release

module hamming_serial_rx #(
  parameter int CLKS_PER_BIT = 2813,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [6:0] palabra_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_q;
  logic [CNT_W-1:0]       baud_cnt;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_q;
  logic                   par_ok;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Synchroniser and edge-detect history preset to 1 so reset looks like an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rxs_q  <= rxs;
    end
  end

`ifdef RX_PARITY_EN
  logic par_ok_q;
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      palabra_o   <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
`ifdef RX_PARITY_EN
      par_ok_q    <= 1'b1;
`endif
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs_q && !rxs) begin
            state    <= START;
            baud_cnt <= '0;
            busy_o   <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt == MID_CNT) begin
            // Restarting the count here puts every later sample at a bit centre.
            baud_cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt         <= '0;
            shift_q[bit_cnt] <= rxs;
            if (bit_cnt == 3'd6) begin
              bit_cnt <= '0;
`ifdef RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            par_ok_q <= ~(^shift_q ^ rxs);
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            if (rxs && par_ok) begin
              palabra_o <= shift_q;
              valid_o   <= 1'b1;
              state     <= IDLE;
              busy_o    <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              if (!rxs) begin
                state <= BREAK;
              end else begin
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        BREAK: begin
          if (rxs) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
